// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StWaitIdle,
        StDone,
        StErr
    } ps2_tx_state_e;

    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam int unsigned FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-stage synchronizer for one PS/2 pin plus a falling-edge detector.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic meta;
    logic hist;

    // Reset to the idle (released, pulled-up) level so no false edge appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            hist <= sync;
        end
    end

    assign fall = hist & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame on
// device clocks, then ACK check and wait for the bus to return idle.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       bus_busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e    state;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       frame_q;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall;
    logic tmo_expired;
    logic unused_dat_fall;

    ps2_line_sync u_clk_sync (
        .clk  (CLOCK_50),
        .rst  (RST),
        .pin  (ps2_clk_in),
        .sync (clk_sync),
        .fall (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk  (CLOCK_50),
        .rst  (RST),
        .pin  (ps2_dat_in),
        .sync (dat_sync),
        .fall (dat_fall)
    );

    assign unused_dat_fall = dat_fall;
    assign tmo_expired     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state      <= StIdle;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            bit_idx    <= '0;
            frame_q    <= '0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            bus_busy   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tx_valid && tx_ready) begin
                        frame_q    <= {STOP_BIT, odd_parity(tx_data), tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        bus_busy   <= 1'b1;
                        state      <= StInhibit;
                    end
                end
                StInhibit: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_dat_oe <= ~START_BIT;
                        state      <= StReq;
                    end
                end
                StReq: begin
                    ps2_clk_oe <= 1'b0;
                    bit_idx    <= '0;
                    tmo_cnt    <= '0;
                    state      <= StShift;
                end
                StShift: begin
                    // A device clock edge beats a coincident timeout.
                    if (clk_fall) begin
                        tmo_cnt    <= '0;
                        ps2_dat_oe <= ~frame_q[0];
                        frame_q    <= {1'b0, frame_q[9:1]};
                        bit_idx    <= bit_idx + 1'b1;
                        if (bit_idx == 4'(FRAME_BITS - 2)) begin
                            state <= StAck;
                        end
                    end else if (tmo_expired) begin
                        ps2_dat_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        state      <= StErr;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StAck: begin
                    if (clk_fall) begin
                        tmo_cnt <= '0;
                        if (!dat_sync) begin
                            state <= StWaitIdle;
                        end else begin
                            tx_err <= 1'b1;
                            state  <= StErr;
                        end
                    end else if (tmo_expired) begin
                        ps2_dat_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        state      <= StErr;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (clk_fall) begin
                        tmo_cnt <= '0;
                    end else if (clk_sync && dat_sync) begin
                        tx_done <= 1'b1;
                        state   <= StDone;
                    end else if (tmo_expired) begin
                        ps2_dat_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        state      <= StErr;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StDone, StErr: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_ready   <= 1'b1;
                    bus_busy   <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-drain PS2_CLK/PS2_DAT pair the keyboard receive path listens on.
- Runs the inhibit / request-to-send sequence, shifts the 11-bit host frame on device-generated clocks, and checks the device ACK.
- Sits beside the keyboard receiver in the driver layer. `bus_busy` lets the integrator mask the receiver while a host frame is on the wire.

Parameters:
- INHIBIT_CYCLES, 5000, CLOCK_50 cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum CLOCK_50 cycles without a device clock falling edge before abort (15 ms).

Ports:
- CLOCK_50    in   1  system clock, 50 MHz.
- RST         in   1  synchronous reset, active-high.
- tx_data     in   8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid    in   1  send request.
- tx_ready    out  1  high only in IDLE.
- tx_done     out  1  one-cycle pulse: frame sent and ACK received.
- tx_err      out  1  one-cycle pulse: missing ACK or timeout.
- bus_busy    out  1  high in every state except IDLE.
- ps2_clk_in  in   1  raw PS2_CLK pin level.
- ps2_dat_in  in   1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release.

Behaviour:
- Interface: one clock, CLOCK_50; RST is synchronous, active-high. All outputs are registered.
- Reset values:
  - tx_ready=1.
  - tx_done=0, tx_err=0, bus_busy=0.
  - ps2_clk_oe=0, ps2_dat_oe=0.
  - State IDLE, counters 0.
- Input conditioning: each pin passes through a 2-FF synchronizer plus a history FF. fall = hist & ~sync. Edge latency is 3 cycles from the pin.
- Handshake: a transfer is accepted on tx_valid && tx_ready. At acceptance, latch the byte and compute parity = ~^tx_data (odd parity). tx_valid while busy is ignored, with no queuing.
- States:
  - IDLE: both oe=0. On accept, go to INHIBIT with clk_oe=1 and cnt=0.
  - INHIBIT: clk_oe=1, cnt increments. At cnt==INHIBIT_CYCLES-1, set dat_oe=1 (start bit) and go to REQ.
  - REQ: one cycle, with clk low and data low. Then release clk (clk_oe=0), set bit index=0, clear the timeout counter, go to SHIFT.
  - SHIFT: on each PS2_CLK fall, drive the next bit, with dat_oe = ~bit:
    - falls 1–8: data LSB first.
    - fall 9: parity.
    - fall 10: stop (dat_oe=0); go to ACK.
  - ACK: on fall 11, sample the synchronized data. 0 = ack, go to WAIT_IDLE. 1 = go to ERR.
  - WAIT_IDLE: wait until synchronized clk and dat are both high, then go to DONE.
  - DONE: tx_done=1 for one cycle, then IDLE.
  - ERR: tx_err=1 for one cycle, both oe=0, then IDLE.
- Timeout:
  - In SHIFT, ACK and WAIT_IDLE, the timeout counter resets on every clk fall.
  - When it reaches TIMEOUT_CYCLES-1, go to ERR. dat_oe is released that cycle.
- Reset mid-operation: on the cycle after RST is sampled:
  - both oe=0, tx_ready=1.
  - no tx_done/tx_err pulse.
  - any partial frame is abandoned.
- Simultaneous events: timeout expiry and a clk fall in the same cycle means the fall wins and the counter clears. RST overrides everything.
- Bit index is 4 bits and never wraps; it saturates in ACK.
- tx_done and tx_err are mutually exclusive and exactly one fires per accepted request, unless RST intervenes.

Decomposition:
- Shared package ps2_pkg:
  - state enum.
  - frame constants: START=0, STOP=1, FRAME_BITS=11.
  - command constants: 0xED, 0xF4, 0xFF, ACK byte 0xFA.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one pin, instantiated twice. It is reusable by the receive path.

Test Plan:
- Send 0xED with a device model (40 us clk half-period, drives ACK low at fall 11):
  - captured frame: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - clk held low ≥5000 cycles before release.
  - tx_done pulses once; tx_err stays 0.
- Parity sweep: 0x00→1, 0x01→0, 0xFF→1, 0xF4→0. Check the device-captured parity for each, and that every frame ends in tx_done.
- No ACK (data stays high at fall 11): tx_err one-cycle pulse, tx_done 0, both oe=0, tx_ready=1.
- Device never clocks after REQ: tx_err exactly TIMEOUT_CYCLES (±3) cycles after clk release, and dat_oe=0 afterwards.
- RST asserted after fall 5: next cycle both oe=0, tx_ready=1, no done/err pulse. A subsequent 0xFF send completes normally.
- tx_valid held high across two bytes 0xF4, 0xED:
  - second byte accepted only after tx_done.
  - bus_busy high throughout each frame.
  - tx_ready low throughout each frame.
